ball_collision_unit: RTL and testbench

BALL_COLLISION_UNIT -- requirements
Module: ball_collision_unit

---
 rtl/ball_collision_unit.sv | 203 ++++++++++++++++++++
 tb/tb_ball_collision_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_unit.sv
// ball_collision_unit: per-frame ball wall/paddle/brick collision resolver with lives and brick bitmap
module ball_collision_unit #(
    parameter int BALL_SIZE    = 32,
    parameter int PADDLE_W     = 100,
    parameter int PADDLE_Y     = 440,
    parameter int BORDER       = 3,
    parameter int RIGHT_LIMIT  = 600,
    parameter int MISS_Y       = 460,
    parameter int BRICK_LEFT   = 64,
    parameter int BRICK_TOP    = 32,
    parameter int BRICK_COLS   = 8,
    parameter int BRICK_ROWS   = 4,
    parameter int BRICK_W_LOG2 = 6,
    parameter int BRICK_H_LOG2 = 4,
    parameter int IDX_W        = 5,
    parameter int LIVES        = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [9:0]                       ball_x,
    input  logic [9:0]                       ball_y,
    input  logic [9:0]                       paddle_x,
    input  logic                             force_flip,
    input  logic                             serve,
    output logic [1:0]                       dir,
    output logic                             lock,
    output logic                             busy,
    output logic                             done,
    output logic [BRICK_ROWS*BRICK_COLS-1:0] brick_alive,
    output logic                             brick_hit,
    output logic [IDX_W-1:0]                 brick_hit_idx,
    output logic [1:0]                       lives,
    output logic                             level_clear,
    output logic                             game_over,
    output logic                             overrun
);
    localparam int NB = BRICK_ROWS * BRICK_COLS;
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] HALF    = 11'(BALL_SIZE / 2);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PY      = 11'(PADDLE_Y);
    localparam logic [10:0] BRD     = 11'(BORDER);
    localparam logic [10:0] RL      = 11'(RIGHT_LIMIT);
    localparam logic [10:0] MY      = 11'(MISS_Y);
    localparam logic [10:0] BL      = 11'(BRICK_LEFT);
    localparam logic [10:0] BT      = 11'(BRICK_TOP);
    localparam logic [10:0] COLS    = 11'(BRICK_COLS);
    localparam logic [10:0] FIELD_W = 11'(BRICK_COLS << BRICK_W_LOG2);
    localparam logic [10:0] FIELD_H = 11'(BRICK_ROWS << BRICK_H_LOG2);

    typedef enum logic [1:0] {IDLE, EVAL, BRICK, COMMIT} state_t;

    state_t state_q, state_d;
    logic [9:0] bx_q, bx_d, by_q, by_d, px_q, px_d;
    logic ff_q, ff_d, top_q, top_d, left_q, left_d, right_q, right_d;
    logic miss_q, miss_d, pad_q, pad_d, brk_q, brk_d;
    logic [IDX_W-1:0] idx_q, idx_d, hit_idx_q, hit_idx_d;
    logic [1:0] dir_q, dir_d, lives_q, lives_d;
    logic lock_q, lock_d, done_q, done_d, hit_q, hit_d, go_q, go_d, ovr_q, ovr_d;
    logic [NB-1:0] alive_q, alive_d;
    logic [10:0] cx, cy, dx, dy;
    logic [IDX_W-1:0] idx;
    logic in_field;

    // Ball centre relative to the brick field; unsigned wrap is caught by the >= checks.
    always_comb begin
        cx       = {1'b0, bx_q} + HALF;
        cy       = {1'b0, by_q} + HALF;
        dx       = cx - BL;
        dy       = cy - BT;
        in_field = (cx >= BL) && (cy >= BT) && (dx < FIELD_W) && (dy < FIELD_H);
        idx      = IDX_W'((dy >> BRICK_H_LOG2) * COLS + (dx >> BRICK_W_LOG2));
    end

    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        px_d      = px_q;
        ff_d      = ff_q;
        top_d     = top_q;
        left_d    = left_q;
        right_d   = right_q;
        miss_d    = miss_q;
        pad_d     = pad_q;
        brk_d     = brk_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        lives_d   = lives_q;
        lock_d    = lock_q;
        alive_d   = alive_q;
        hit_idx_d = hit_idx_q;
        done_d    = 1'b0;
        hit_d     = 1'b0;
        ovr_d     = ovr_q | (tick && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (serve && lives_q != 2'd0) lock_d = 1'b0;
                if (tick && !lock_q && !go_q) begin
                    bx_d    = ball_x;
                    by_d    = ball_y;
                    px_d    = paddle_x;
                    ff_d    = force_flip;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                top_d   = {1'b0, by_q} <= BRD;
                left_d  = {1'b0, bx_q} <= BRD;
                right_d = {1'b0, bx_q} >= RL;
                miss_d  = {1'b0, by_q} >= MY;
                pad_d   = !dir_q[1] && ({1'b0, by_q} + BS >= PY) && ({1'b0, bx_q} + BS > {1'b0, px_q})
                          && ({1'b0, bx_q} < {1'b0, px_q} + PW);
                state_d = BRICK;
            end
            BRICK: begin
                brk_d   = in_field && alive_q[idx];
                idx_d   = idx;
                state_d = COMMIT;
            end
            COMMIT: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (brk_q) begin
                    alive_d[idx_q] = 1'b0;
                    hit_d          = 1'b1;
                    hit_idx_d      = idx_q;
                end
                if (miss_q) begin
                    dir_d   = 2'b10;
                    lock_d  = 1'b1;
                    lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
                end else begin
                    dir_d[1] = top_q ? 1'b0 : pad_q ? 1'b1 : dir_q[1] ^ brk_q ^ ff_q;
                    dir_d[0] = (left_q && !right_q) ? 1'b0 : (right_q && !left_q) ? 1'b1 : dir_q[0];
                end
            end
            default: state_d = IDLE;
        endcase
        go_d = go_q | (lives_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bx_q      <= '0;
            by_q      <= '0;
            px_q      <= '0;
            ff_q      <= 1'b0;
            top_q     <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            miss_q    <= 1'b0;
            pad_q     <= 1'b0;
            brk_q     <= 1'b0;
            idx_q     <= '0;
            dir_q     <= 2'b10;
            lives_q   <= 2'(LIVES);
            lock_q    <= 1'b0;
            alive_q   <= '1;
            hit_idx_q <= '0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            go_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            px_q      <= px_d;
            ff_q      <= ff_d;
            top_q     <= top_d;
            left_q    <= left_d;
            right_q   <= right_d;
            miss_q    <= miss_d;
            pad_q     <= pad_d;
            brk_q     <= brk_d;
            idx_q     <= idx_d;
            dir_q     <= dir_d;
            lives_q   <= lives_d;
            lock_q    <= lock_d;
            alive_q   <= alive_d;
            hit_idx_q <= hit_idx_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            go_q      <= go_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dir           = dir_q;
    assign lock          = lock_q;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign brick_alive   = alive_q;
    assign brick_hit     = hit_q;
    assign brick_hit_idx = hit_idx_q;
    assign lives         = lives_q;
    assign level_clear   = ~|alive_q;
    assign game_over     = go_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_ball_collision_unit.sv
// tb_ball_collision_unit: directed self-checking bench for ball_collision_unit
module tb_ball_collision_unit;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, force_flip = 1'b0, serve = 1'b0;
    logic [9:0] ball_x = '0, ball_y = '0, paddle_x = '0;
    logic [1:0] dir, lives;
    logic lock, busy, done, brick_hit, level_clear, game_over, overrun;
    logic [31:0] brick_alive;
    logic [4:0] brick_hit_idx;
    int n_chk = 0, n_fail = 0, nd;

    ball_collision_unit dut (
        .clk(clk), .rst(rst), .tick(tick), .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
        .force_flip(force_flip), .serve(serve), .dir(dir), .lock(lock), .busy(busy), .done(done),
        .brick_alive(brick_alive), .brick_hit(brick_hit), .brick_hit_idx(brick_hit_idx), .lives(lives),
        .level_clear(level_clear), .game_over(game_over), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dir"}, dir, 2'b10);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_hit"}, brick_hit, 0);
        chk({tag, "_idx"}, brick_hit_idx, 0);
        chk({tag, "_lives"}, lives, 3);
        chk({tag, "_alive"}, brick_alive, 32'hFFFF_FFFF);
        chk({tag, "_clear"}, level_clear, 0);
        chk({tag, "_go"}, game_over, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    // Tick sampled on the first edge; done expected on the fourth.
    task automatic update(input logic [9:0] x, input logic [9:0] y, input logic [9:0] px,
                          input logic ff, input string tag);
        ball_x = x;
        ball_y = y;
        paddle_x = px;
        force_flip = ff;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        force_flip = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        cyc();
        cyc();
        chk({tag, "_early"}, done, 0);
        cyc();
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic count_done(input int n);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (done) nd++;
        end
    endtask

    initial begin
        cyc();
        cyc();
        check_reset("rst");
        rst = 1'b0;

        update(300, 2, 0, 0, "top");
        chk("top_dir", dir, 2'b00);
        chk("top_alive", brick_alive, 32'hFFFF_FFFF);
        chk("top_hit", brick_hit, 0);
        chk("top_idle", busy, 0);
        cyc();
        chk("top_pulse", done, 0);

        update(250, 410, 200, 0, "pad");
        chk("pad_dir", dir, 2'b10);
        update(250, 410, 200, 0, "pad_up");
        chk("pad_up_dir", dir, 2'b10);

        update(80, 40, 0, 0, "brk");
        chk("brk_hit", brick_hit, 1);
        chk("brk_idx", brick_hit_idx, 8);
        chk("brk_alive", brick_alive, 32'hFFFF_FEFF);
        chk("brk_dir", dir, 2'b00);
        cyc();
        chk("brk_pulse", brick_hit, 0);
        update(80, 40, 0, 0, "brk_dead");
        chk("brk_dead_hit", brick_hit, 0);
        chk("brk_dead_dir", dir, 2'b00);
        chk("brk_dead_alive", brick_alive, 32'hFFFF_FEFF);

        update(600, 200, 0, 0, "right");
        chk("right_dir", dir, 2'b01);
        update(250, 410, 200, 0, "pad_w");
        chk("pad_w_dir", dir, 2'b11);
        update(2, 2, 0, 1, "corner");
        chk("corner_dir", dir, 2'b00);
        update(144, 40, 0, 1, "cancel");
        chk("cancel_dir", dir, 2'b00);
        chk("cancel_hit", brick_hit, 1);
        chk("cancel_idx", brick_hit_idx, 9);
        chk("cancel_alive", brick_alive, 32'hFFFF_FCFF);
        update(300, 200, 0, 1, "flip");
        chk("flip_dir", dir, 2'b10);
        chk("flip_clear", level_clear, 0);

        ball_x = 300;
        ball_y = 200;
        tick = 1'b1;
        cyc();
        cyc();
        tick = 1'b0;
        count_done(6);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ndone", nd, 1);
        chk("ovr_dir", dir, 2'b10);

        ball_x = 208;
        ball_y = 40;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset("abort");
        count_done(5);
        chk("abort_ndone", nd, 0);
        chk("abort_alive2", brick_alive, 32'hFFFF_FFFF);

        update(300, 470, 0, 0, "miss1");
        chk("miss1_dir", dir, 2'b10);
        chk("miss1_lock", lock, 1);
        chk("miss1_lives", lives, 2);
        chk("miss1_go", game_over, 0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("locked_idle", busy, 0);
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("serve1_lock", lock, 0);
        update(300, 470, 0, 0, "miss2");
        chk("miss2_lives", lives, 1);
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("serve2_lock", lock, 0);
        update(300, 470, 0, 0, "miss3");
        chk("miss3_lives", lives, 0);
        chk("miss3_go", game_over, 1);
        chk("miss3_lock", lock, 1);
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("serve3_lock", lock, 1);
        ball_y = 100;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        count_done(6);
        chk("over_ndone", nd, 0);
        chk("over_busy", busy, 0);
        chk("over_go", game_over, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
